frame_bram_arbiter: RTL and testbench
=====================================

Name: frame_bram_arbiter

Overview:
- Shares the single-port 320x240 frame BRAM (8-bit pixels, 17-bit address) between three requesters: the VGA reader, the compare-stage read/modify/write engine, and an internal full-frame clear sequencer.
- Issues at most one BRAM access per cycle, returns tagged read data after the fixed BRAM read latency, and guarantees the compare engine forward progress against continuous VGA traffic.
- Sits in the top level between the compare engine, the VGA pixel fetch and the frame BRAM instance.

Parameters:
- ADDR_W, 17, BRAM address width.
- DATA_W, 8, pixel width.
- NUM_PIXELS, 76800, valid addresses are 0..NUM_PIXELS-1.
- READ_LATENCY, 2, cycles from address on BRAM to valid bram_dout_in.
- VGA_BURST_MAX, 4, consecutive VGA grants allowed while cmp_req_in is pending.
- CLEAR_VALUE, 8'h00, pixel value written by the clear sequencer.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-high reset.
- vga_req_in  in  1  VGA read request (level).
- vga_addr_in  in  ADDR_W  VGA read address.
- vga_grant_out  out  1  VGA request accepted this cycle.
- vga_rdata_out  out  DATA_W  VGA read data.
- vga_rvalid_out  out  1  vga_rdata_out valid (1-cycle pulse).
- cmp_req_in  in  1  compare access request (level).
- cmp_we_in  in  1  1 = write, 0 = read.
- cmp_addr_in  in  ADDR_W  compare address.
- cmp_wdata_in  in  DATA_W  compare write data.
- cmp_grant_out  out  1  compare request accepted this cycle.
- cmp_rdata_out  out  DATA_W  compare read data.
- cmp_rvalid_out  out  1  cmp_rdata_out valid (1-cycle pulse).
- clear_start_in  in  1  start full-frame clear (pulse).
- clear_busy_out  out  1  clear in progress.
- clear_done_out  out  1  clear finished (1-cycle pulse).
- bram_addr_out  out  ADDR_W  BRAM address.
- bram_din_out  out  DATA_W  BRAM write data.
- bram_we_out  out  1  BRAM write enable.
- bram_dout_in  in  DATA_W  BRAM read data.

Behaviour:
- Reset: all outputs, grant counters, clear counter and read pipeline cleared to 0; FSM goes to IDLE. Reset mid-clear aborts the clear and does not pulse done. In-flight reads are dropped; no rvalid is asserted after reset.
- Arbitration:
  - Requests are sampled at edge N. The BRAM outputs and the winner's grant are registered and are high for exactly one cycle (N+1).
  - A requester holds req, addr and data stable until it sees its grant. If req is still high after the grant, it is treated as a new request.
  - Priority: VGA > clear > compare.
  - Exception: if vga_burst_cnt == VGA_BURST_MAX and cmp_req_in is high and no clear is active, compare wins that slot. vga_burst_cnt increments on each VGA grant while cmp_req_in is high and resets on any compare grant or when cmp_req_in is low.
  - No request issued: bram_we_out = 0 and bram_addr_out holds its previous value.
- Reads:
  - A READ_LATENCY-deep shift register carries {vld, owner} for each read.
  - The matching rvalid pulses in cycle N+1+READ_LATENCY with rdata = bram_dout_in.
  - rdata holds its value until the next valid for the same owner.
- Compare writes: bram_we_out = 1 in the grant cycle. No rvalid is generated.
- Out-of-range address (>= NUM_PIXELS, e.g. the 17'h12C01 off-frame sentinel):
  - The grant is still given and bram_we_out is forced to 0.
  - A read of such an address returns 0 with rvalid at the normal latency; the real BRAM data is ignored.
- Clear FSM:
  - IDLE: clear_start_in moves to CLEARING with clr_addr = 0 and clear_busy_out = 1.
  - CLEARING: in each cycle with no VGA request (or while the VGA burst limit is satisfied), write CLEAR_VALUE to clr_addr and increment clr_addr. Compare requests are never granted during CLEARING. After writing NUM_PIXELS-1, go to DONE.
  - DONE: one cycle with clear_done_out = 1 and clear_busy_out = 0, then IDLE.
  - clear_start_in while in CLEARING or DONE is ignored.
- Simultaneous VGA, compare and clear requests: exactly one grant per cycle. Grants are never given to a requester whose req is low.

Test Plan:
- Only vga_req_in high, addr 0x00010, BRAM preloaded with 0x5A: vga_grant_out high 1 cycle later; vga_rvalid_out with 0x5A 3 cycles after the request is sampled.
- cmp write addr 0x00100 data 0xC1, then cmp read same addr: bram_we_out = 1 with the correct addr/data; the read returns 0xC1 with cmp_rvalid_out.
- vga_req_in held continuously with cmp_req_in high: the grant sequence is 4 VGA grants, 1 compare grant, repeating.
- cmp write to 17'h12C01: cmp_grant_out asserted, bram_we_out stays 0; a read of 17'h12C01 returns 0x00 with valid.
- clear_start_in with no VGA traffic: NUM_PIXELS consecutive writes of 0x00 to addr 0..76799; clear_done_out pulses once; cmp_req_in is not granted until done; a repeat clear_start_in mid-clear is ignored.
- Assert rst_in mid-clear with 2 reads in flight: all outputs go to 0 immediately; no rvalid and no clear_done_out afterwards.

Source files
------------

// File: rtl/frame_bram_arbiter.sv
// Frame BRAM arbiter: shares one single-port frame BRAM between the VGA
// reader, the compare read/modify/write engine and a full-frame clear
// sequencer. One access per cycle, registered BRAM drive, tagged read return.
module frame_bram_arbiter #(
    parameter int          ADDR_W        = 17,
    parameter int          DATA_W        = 8,
    parameter int          NUM_PIXELS    = 76800,
    parameter int          READ_LATENCY  = 2,
    parameter int          VGA_BURST_MAX = 4,
    parameter logic [7:0]  CLEAR_VALUE   = 8'h00
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              vga_req_in,
    input  logic [ADDR_W-1:0] vga_addr_in,
    output logic              vga_grant_out,
    output logic [DATA_W-1:0] vga_rdata_out,
    output logic              vga_rvalid_out,
    input  logic              cmp_req_in,
    input  logic              cmp_we_in,
    input  logic [ADDR_W-1:0] cmp_addr_in,
    input  logic [DATA_W-1:0] cmp_wdata_in,
    output logic              cmp_grant_out,
    output logic [DATA_W-1:0] cmp_rdata_out,
    output logic              cmp_rvalid_out,
    input  logic              clear_start_in,
    output logic              clear_busy_out,
    output logic              clear_done_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [DATA_W-1:0] bram_din_out,
    output logic              bram_we_out,
    input  logic [DATA_W-1:0] bram_dout_in
);

    localparam int                CNT_W     = $clog2(VGA_BURST_MAX + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CLEARING, ST_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]   bram_din_q, bram_din_d;
    logic                bram_we_q, bram_we_d;
    logic                vga_grant_q, vga_grant_d;
    logic                cmp_grant_q, cmp_grant_d;
    // Read issued alongside the registered BRAM address: valid, owner (1 = compare), off-frame.
    logic                iss_vld_q, iss_vld_d;
    logic                iss_cmp_q, iss_cmp_d;
    logic                iss_oor_q, iss_oor_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_cmp_q, pipe_cmp_d;
    logic [READ_LATENCY-1:0] pipe_oor_q, pipe_oor_d;
    logic [DATA_W-1:0]   vga_hold_q, vga_hold_d;
    logic [DATA_W-1:0]   cmp_hold_q, cmp_hold_d;

    logic                clear_active;
    logic                burst_limit;
    logic                grant_vga, grant_clr, grant_cmp;
    logic                vga_in_range, cmp_in_range;
    logic                tail_vld, tail_cmp, tail_oor;
    logic [DATA_W-1:0]   rd_data;

    assign clear_active = (state_q == ST_CLEARING);
    assign vga_in_range = (vga_addr_in <= LAST_ADDR);
    assign cmp_in_range = (cmp_addr_in <= LAST_ADDR);
    // Compare steals the slot once VGA has used up its burst allowance.
    assign burst_limit  = (burst_cnt_q == CNT_W'(VGA_BURST_MAX)) && cmp_req_in && !clear_active;
    assign grant_vga    = vga_req_in && !burst_limit;
    assign grant_clr    = !grant_vga && clear_active;
    assign grant_cmp    = !grant_vga && !clear_active && cmp_req_in;

    // Arbitration, BRAM drive, burst counting and clear FSM next state.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        burst_cnt_d = burst_cnt_q;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        bram_we_d   = 1'b0;
        vga_grant_d = 1'b0;
        cmp_grant_d = 1'b0;
        iss_vld_d   = 1'b0;
        iss_cmp_d   = 1'b0;
        iss_oor_d   = 1'b0;

        if (grant_vga) begin
            bram_addr_d = vga_addr_in;
            vga_grant_d = 1'b1;
            iss_vld_d   = 1'b1;
            iss_oor_d   = !vga_in_range;
        end else if (grant_clr) begin
            bram_addr_d = clr_addr_q;
            bram_din_d  = CLEAR_VALUE;
            bram_we_d   = 1'b1;
        end else if (grant_cmp) begin
            bram_addr_d = cmp_addr_in;
            cmp_grant_d = 1'b1;
            if (cmp_we_in) begin
                bram_din_d = cmp_wdata_in;
                bram_we_d  = cmp_in_range;
            end else begin
                iss_vld_d = 1'b1;
                iss_cmp_d = 1'b1;
                iss_oor_d = !cmp_in_range;
            end
        end

        if (grant_cmp || !cmp_req_in) begin
            burst_cnt_d = '0;
        end else if (grant_vga && burst_cnt_q != CNT_W'(VGA_BURST_MAX)) begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (clear_start_in) begin
                    state_d    = ST_CLEARING;
                    clr_addr_d = '0;
                end
            end
            ST_CLEARING: begin
                if (grant_clr) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        clr_addr_d = clr_addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read-return shift register: stage 0 follows the issued read by one cycle.
    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                assign pipe_vld_d[gi] = iss_vld_q;
                assign pipe_cmp_d[gi] = iss_cmp_q;
                assign pipe_oor_d[gi] = iss_oor_q;
            end else begin : g_shift
                assign pipe_vld_d[gi] = pipe_vld_q[gi-1];
                assign pipe_cmp_d[gi] = pipe_cmp_q[gi-1];
                assign pipe_oor_d[gi] = pipe_oor_q[gi-1];
            end
        end
    endgenerate

    assign tail_vld = pipe_vld_q[READ_LATENCY-1];
    assign tail_cmp = pipe_cmp_q[READ_LATENCY-1];
    assign tail_oor = pipe_oor_q[READ_LATENCY-1];
    assign rd_data  = tail_oor ? '0 : bram_dout_in;

    // Read data is passed through on the valid cycle and held afterwards per owner.
    always_comb begin
        vga_hold_d = vga_hold_q;
        cmp_hold_d = cmp_hold_q;
        if (tail_vld && !tail_cmp) vga_hold_d = rd_data;
        if (tail_vld && tail_cmp)  cmp_hold_d = rd_data;
    end

    assign vga_rvalid_out = tail_vld && !tail_cmp;
    assign cmp_rvalid_out = tail_vld && tail_cmp;
    assign vga_rdata_out  = vga_rvalid_out ? rd_data : vga_hold_q;
    assign cmp_rdata_out  = cmp_rvalid_out ? rd_data : cmp_hold_q;

    // State register; reset drops the clear and every in-flight read.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            clr_addr_q  <= '0;
            burst_cnt_q <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            bram_we_q   <= 1'b0;
            vga_grant_q <= 1'b0;
            cmp_grant_q <= 1'b0;
            iss_vld_q   <= 1'b0;
            iss_cmp_q   <= 1'b0;
            iss_oor_q   <= 1'b0;
            pipe_vld_q  <= '0;
            pipe_cmp_q  <= '0;
            pipe_oor_q  <= '0;
            vga_hold_q  <= '0;
            cmp_hold_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            burst_cnt_q <= burst_cnt_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            bram_we_q   <= bram_we_d;
            vga_grant_q <= vga_grant_d;
            cmp_grant_q <= cmp_grant_d;
            iss_vld_q   <= iss_vld_d;
            iss_cmp_q   <= iss_cmp_d;
            iss_oor_q   <= iss_oor_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_cmp_q  <= pipe_cmp_d;
            pipe_oor_q  <= pipe_oor_d;
            vga_hold_q  <= vga_hold_d;
            cmp_hold_q  <= cmp_hold_d;
        end
    end

    assign bram_addr_out  = bram_addr_q;
    assign bram_din_out   = bram_din_q;
    assign bram_we_out    = bram_we_q;
    assign vga_grant_out  = vga_grant_q;
    assign cmp_grant_out  = cmp_grant_q;
    assign clear_busy_out = (state_q == ST_CLEARING);
    assign clear_done_out = (state_q == ST_DONE);

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// Directed bench for frame_bram_arbiter with a 2-cycle-latency BRAM model.
module tb_frame_bram_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        vga_req_in = 1'b0;
    logic [16:0] vga_addr_in = '0;
    logic        vga_grant_out;
    logic [7:0]  vga_rdata_out;
    logic        vga_rvalid_out;
    logic        cmp_req_in = 1'b0;
    logic        cmp_we_in = 1'b0;
    logic [16:0] cmp_addr_in = '0;
    logic [7:0]  cmp_wdata_in = '0;
    logic        cmp_grant_out;
    logic [7:0]  cmp_rdata_out;
    logic        cmp_rvalid_out;
    logic        clear_start_in = 1'b0;
    logic        clear_busy_out;
    logic        clear_done_out;
    logic [16:0] bram_addr_out;
    logic [7:0]  bram_din_out;
    logic        bram_we_out;
    logic [7:0]  bram_dout_in;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:131071];
    logic [7:0] rd_stage;

    always #5 clk_in = ~clk_in;

    // BRAM model: address in cycle k, data visible in cycle k+2.
    always @(posedge clk_in) begin
        if (bram_we_out) mem[bram_addr_out] <= bram_din_out;
        rd_stage     <= mem[bram_addr_out];
        bram_dout_in <= rd_stage;
    end

    frame_bram_arbiter dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .vga_req_in(vga_req_in), .vga_addr_in(vga_addr_in),
        .vga_grant_out(vga_grant_out), .vga_rdata_out(vga_rdata_out),
        .vga_rvalid_out(vga_rvalid_out),
        .cmp_req_in(cmp_req_in), .cmp_we_in(cmp_we_in),
        .cmp_addr_in(cmp_addr_in), .cmp_wdata_in(cmp_wdata_in),
        .cmp_grant_out(cmp_grant_out), .cmp_rdata_out(cmp_rdata_out),
        .cmp_rvalid_out(cmp_rvalid_out),
        .clear_start_in(clear_start_in), .clear_busy_out(clear_busy_out),
        .clear_done_out(clear_done_out),
        .bram_addr_out(bram_addr_out), .bram_din_out(bram_din_out),
        .bram_we_out(bram_we_out), .bram_dout_in(bram_dout_in)
    );

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        logic [63:0] got;
        rst_in = 1'b1;
        tick(); tick();
        got = {bram_addr_out, bram_din_out, bram_we_out, vga_grant_out, cmp_grant_out,
               vga_rvalid_out, cmp_rvalid_out, vga_rdata_out, cmp_rdata_out,
               clear_busy_out, clear_done_out};
        tests_run++;
        if (got !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", got);
        end
        rst_in = 1'b0;
        tick();
        tests_run++;
        if (vga_grant_out !== 1'b0 || cmp_grant_out !== 1'b0 || bram_we_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: vga_grant=%b cmp_grant=%b we=%b required 0 0 0",
                     vga_grant_out, cmp_grant_out, bram_we_out);
        end
        $display("[TB] reset: outputs cleared");
    endtask

    task automatic test_vga_read();
        mem[17'h10] = 8'h5A;
        vga_req_in = 1'b1; vga_addr_in = 17'h10;
        tick();
        vga_req_in = 1'b0;
        tests_run++;
        if (vga_grant_out !== 1'b1 || bram_addr_out !== 17'h10 || bram_we_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL vga_grant: grant=%b addr=%h we=%b required 1 00010 0",
                     vga_grant_out, bram_addr_out, bram_we_out);
        end
        tick();
        tests_run++;
        if (vga_grant_out !== 1'b0 || vga_rvalid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL vga_early: grant=%b rvalid=%b required 0 0", vga_grant_out, vga_rvalid_out);
        end
        tick();
        tests_run++;
        if (vga_rvalid_out !== 1'b1 || vga_rdata_out !== 8'h5A || cmp_rvalid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL vga_rdata: rvalid=%b data=%h cmp_rvalid=%b required 1 5a 0",
                     vga_rvalid_out, vga_rdata_out, cmp_rvalid_out);
        end
        tick();
        tests_run++;
        if (vga_rvalid_out !== 1'b0 || vga_rdata_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL vga_hold: rvalid=%b data=%h required 0 5a", vga_rvalid_out, vga_rdata_out);
        end
        $display("[TB] vga read addr 00010 data %h", vga_rdata_out);
    endtask

    task automatic test_cmp_write_read();
        cmp_req_in = 1'b1; cmp_we_in = 1'b1; cmp_addr_in = 17'h100; cmp_wdata_in = 8'hC1;
        tick();
        cmp_req_in = 1'b0;
        tests_run++;
        if (cmp_grant_out !== 1'b1 || bram_we_out !== 1'b1 || bram_addr_out !== 17'h100 ||
            bram_din_out !== 8'hC1) begin
            tests_failed++;
            $display("FAIL cmp_write: grant=%b we=%b addr=%h din=%h required 1 1 00100 c1",
                     cmp_grant_out, bram_we_out, bram_addr_out, bram_din_out);
        end
        tick();
        tests_run++;
        if (bram_we_out !== 1'b0 || cmp_grant_out !== 1'b0 || cmp_rvalid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL cmp_write_end: we=%b grant=%b rvalid=%b required 0 0 0",
                     bram_we_out, cmp_grant_out, cmp_rvalid_out);
        end
        cmp_req_in = 1'b1; cmp_we_in = 1'b0;
        tick();
        cmp_req_in = 1'b0;
        tests_run++;
        if (cmp_grant_out !== 1'b1 || bram_we_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL cmp_read_grant: grant=%b we=%b required 1 0", cmp_grant_out, bram_we_out);
        end
        tick(); tick();
        tests_run++;
        if (cmp_rvalid_out !== 1'b1 || cmp_rdata_out !== 8'hC1 || vga_rvalid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL cmp_rdata: rvalid=%b data=%h vga_rvalid=%b required 1 c1 0",
                     cmp_rvalid_out, cmp_rdata_out, vga_rvalid_out);
        end
        $display("[TB] cmp write/read addr 00100 data %h", cmp_rdata_out);
        tick();
    endtask

    task automatic test_burst();
        logic exp_cmp;
        vga_req_in = 1'b1; vga_addr_in = 17'h20;
        cmp_req_in = 1'b1; cmp_we_in = 1'b0; cmp_addr_in = 17'h30;
        for (int i = 0; i < 10; i++) begin
            tick();
            exp_cmp = ((i % 5) == 4);
            tests_run++;
            if (vga_grant_out !== !exp_cmp || cmp_grant_out !== exp_cmp) begin
                tests_failed++;
                $display("FAIL burst_slot%0d: vga_grant=%b cmp_grant=%b required %b %b",
                         i, vga_grant_out, cmp_grant_out, !exp_cmp, exp_cmp);
            end
            $display("[TB] burst slot %0d vga=%b cmp=%b", i, vga_grant_out, cmp_grant_out);
        end
        vga_req_in = 1'b0; cmp_req_in = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_oor();
        mem[17'h12C01] = 8'hEE;
        cmp_req_in = 1'b1; cmp_we_in = 1'b1; cmp_addr_in = 17'h12C01; cmp_wdata_in = 8'h77;
        tick();
        cmp_req_in = 1'b0;
        tests_run++;
        if (cmp_grant_out !== 1'b1 || bram_we_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL oor_write: grant=%b we=%b required 1 0", cmp_grant_out, bram_we_out);
        end
        tick();
        cmp_req_in = 1'b1; cmp_we_in = 1'b0;
        tick();
        cmp_req_in = 1'b0;
        tick(); tick();
        tests_run++;
        if (cmp_rvalid_out !== 1'b1 || cmp_rdata_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL oor_read: rvalid=%b data=%h required 1 00", cmp_rvalid_out, cmp_rdata_out);
        end
        $display("[TB] off-frame read 12c01 data %h", cmp_rdata_out);
        tick();
    endtask

    task automatic test_clear();
        int writes = 0;
        int seq_err = 0;
        int done_cnt = 0;
        int cmp_early = 0;
        int exp_addr = 0;
        int extra = 0;
        bit seen_done = 0;
        mem[0] = 8'h11; mem[76799] = 8'h22; mem[300] = 8'h33;
        clear_start_in = 1'b1;
        tick();
        clear_start_in = 1'b0;
        tests_run++;
        if (clear_busy_out !== 1'b1 || clear_done_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_busy: busy=%b done=%b required 1 0", clear_busy_out, clear_done_out);
        end
        cmp_req_in = 1'b1; cmp_we_in = 1'b0; cmp_addr_in = 17'h40;
        for (int i = 0; i < 80000 && !seen_done; i++) begin
            clear_start_in = (i == 1000);
            tick();
            if (bram_we_out) begin
                if (bram_addr_out !== 17'(exp_addr) || bram_din_out !== 8'h00) seq_err++;
                exp_addr++;
                writes++;
            end
            if (cmp_grant_out) cmp_early++;
            if (clear_done_out) begin
                done_cnt++;
                seen_done = 1;
            end
        end
        clear_start_in = 1'b0;
        tests_run++;
        if (!seen_done) begin
            tests_failed++;
            $display("FAIL clear_timeout: done seen=%0d required 1", seen_done);
        end
        tests_run++;
        if (writes !== 76800 || seq_err !== 0) begin
            tests_failed++;
            $display("FAIL clear_writes: writes=%0d seq_errors=%0d required 76800 0", writes, seq_err);
        end
        tests_run++;
        if (done_cnt !== 1 || cmp_early !== 0) begin
            tests_failed++;
            $display("FAIL clear_done_cmp: done_pulses=%0d cmp_grants=%0d required 1 0",
                     done_cnt, cmp_early);
        end
        tick();
        cmp_req_in = 1'b0;
        tests_run++;
        if (cmp_grant_out !== 1'b1 || clear_busy_out !== 1'b0 || clear_done_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL clear_after: cmp_grant=%b busy=%b done=%b required 1 0 0",
                     cmp_grant_out, clear_busy_out, clear_done_out);
        end
        tests_run++;
        if (mem[0] !== 8'h00 || mem[300] !== 8'h00 || mem[76799] !== 8'h00) begin
            tests_failed++;
            $display("FAIL clear_mem: mem0=%h mem300=%h mem76799=%h required 00 00 00",
                     mem[0], mem[300], mem[76799]);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (clear_done_out || clear_busy_out || bram_we_out) extra++;
        end
        tests_run++;
        if (extra !== 0) begin
            tests_failed++;
            $display("FAIL clear_restart: extra activity cycles=%0d required 0", extra);
        end
        $display("[TB] clear: %0d writes, %0d done pulses", writes, done_cnt);
    endtask

    task automatic test_reset_mid_clear();
        logic [63:0] got;
        int stray = 0;
        clear_start_in = 1'b1;
        tick();
        clear_start_in = 1'b0;
        repeat (20) tick();
        vga_req_in = 1'b1; vga_addr_in = 17'h10;
        tick();
        tick();
        vga_req_in = 1'b0;
        tests_run++;
        if (vga_grant_out !== 1'b1 || clear_busy_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_setup: vga_grant=%b busy=%b required 1 1", vga_grant_out, clear_busy_out);
        end
        #2;
        rst_in = 1'b1;
        #1;
        got = {bram_addr_out, bram_din_out, bram_we_out, vga_grant_out, cmp_grant_out,
               vga_rvalid_out, cmp_rvalid_out, vga_rdata_out, cmp_rdata_out,
               clear_busy_out, clear_done_out};
        tests_run++;
        if (got !== 64'd0) begin
            tests_failed++;
            $display("FAIL rst_async: got %h required 0", got);
        end
        tick(); tick();
        rst_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (vga_rvalid_out || cmp_rvalid_out || clear_done_out || clear_busy_out || bram_we_out)
                stray++;
        end
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL rst_after: stray activity cycles=%0d required 0", stray);
        end
        $display("[TB] reset mid-clear: stray cycles %0d", stray);
    endtask

    initial begin
        test_reset();
        test_vga_read();
        test_cmp_write_read();
        test_burst();
        test_oor();
        test_clear();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
